// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB against a 1-cycle registered read port.
// Define TLB_FILL_LFSR_EN to pick TLBFILL victims from a 16-bit LFSR instead of a free-running counter.

package tlb_maint_pkg;
    localparam int TLB_ENTRY_NUM_DEF = 64;

    typedef struct packed {
        logic        e;
        logic        g;
        logic        huge;
        logic [9:0]  asid;
        logic [18:0] vppn;
    } tlb_key_t;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        tlb_key_t  key;
        tlb_page_t p0;
        tlb_page_t p1;
    } tlb_entry_t;

    typedef struct packed {
        logic [TLB_ENTRY_NUM_DEF-1:0] we;
        tlb_entry_t                   entry;
    } tlb_write_req_t;
endpackage

// state   | meaning
// IDLE    | ready for a new op
// WRITE   | single completion cycle: WR/FILL write pulse, or illegal-op response
// READ    | index issued, data returned, response cycle
// SCAN    | walk all entries for SRCH/INV; last cycle carries the response
module tlb_maint_ctrl
    import tlb_maint_pkg::*;
#(
    parameter int TLB_ENTRY_NUM = TLB_ENTRY_NUM_DEF,
    parameter int IDX_W         = $clog2(TLB_ENTRY_NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [4:0]       req_inv_op,
    input  logic [IDX_W-1:0] req_index,
    input  logic [9:0]       req_asid,
    input  logic [31:0]      req_va,
    input  tlb_entry_t       req_entry,
    output logic [IDX_W-1:0] tlb_rd_idx,
    input  tlb_entry_t       tlb_rd_entry,
    output tlb_write_req_t   tlb_write_req_o,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [IDX_W-1:0] resp_index,
    output tlb_entry_t       resp_entry,
    output logic             resp_illegal
);

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRY_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_SCAN} state_t;

    state_t           state_q, state_n;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_n;
    logic [IDX_W-1:0] cmp_idx_q, cmp_idx_n;
    logic             issue_q, issue_n;
    logic             cmp_vld_q, cmp_vld_n;
    logic             done_q, done_n;
    logic             is_inv_q, is_inv_n;
    logic [4:0]       inv_op_q, inv_op_n;
    logic [9:0]       asid_q, asid_n;
    logic [18:0]      vpn_q, vpn_n;
    tlb_write_req_t   wr_q, wr_n;
    logic             resp_valid_q, resp_valid_n;
    logic             resp_hit_q, resp_hit_n;
    logic [IDX_W-1:0] resp_index_q, resp_index_n;
    tlb_entry_t       resp_entry_q, resp_entry_n;
    logic             resp_illegal_q, resp_illegal_n;

    logic [IDX_W-1:0] fill_idx;
    logic [IDX_W-1:0] wr_idx;
    wire unused_va = ^req_va[12:0];

`ifdef TLB_FILL_LFSR_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign fill_idx = lfsr_q[IDX_W-1:0];
    wire unused_lfsr = ^lfsr_q[15:IDX_W];
`else
    logic [IDX_W-1:0] fill_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) fill_cnt_q <= '0;
        else        fill_cnt_q <= fill_cnt_q + IDX_W'(1);
    end

    assign fill_idx = fill_cnt_q;
`endif

    assign wr_idx = (req_op == OP_FILL) ? fill_idx : req_index;

    // Match terms for the entry currently on the read port
    tlb_key_t rd_key;
    logic     asid_eq, va_eq, srch_hit, inv_sel, inv_hit;

    assign rd_key   = tlb_rd_entry.key;
    assign asid_eq  = (rd_key.asid == asid_q);
    assign va_eq    = rd_key.huge ? (vpn_q[18:9] == rd_key.vppn[18:9]) : (vpn_q == rd_key.vppn);
    assign srch_hit = rd_key.e && (rd_key.g || asid_eq) && va_eq;
    assign inv_hit  = rd_key.e && inv_sel;

    always_comb begin
        inv_sel = 1'b0;
        case (inv_op_q)
            5'd0, 5'd1: inv_sel = 1'b1;
            5'd2:       inv_sel = rd_key.g;
            5'd3:       inv_sel = !rd_key.g;
            5'd4:       inv_sel = !rd_key.g && asid_eq;
            5'd5:       inv_sel = !rd_key.g && asid_eq && va_eq;
            5'd6:       inv_sel = (rd_key.g || asid_eq) && va_eq;
            default:    inv_sel = 1'b0;
        endcase
    end

    always_comb begin
        state_n        = state_q;
        rd_idx_n       = rd_idx_q;
        cmp_idx_n      = cmp_idx_q;
        issue_n        = 1'b0;
        cmp_vld_n      = 1'b0;
        done_n         = done_q;
        is_inv_n       = is_inv_q;
        inv_op_n       = inv_op_q;
        asid_n         = asid_q;
        vpn_n          = vpn_q;
        wr_n           = '0;
        resp_valid_n   = 1'b0;
        resp_hit_n     = 1'b0;
        resp_index_n   = '0;
        resp_entry_n   = '0;
        resp_illegal_n = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    is_inv_n = (req_op == OP_INV);
                    inv_op_n = req_inv_op;
                    asid_n   = req_asid;
                    vpn_n    = req_va[31:13];
                    done_n   = 1'b0;
                    case (req_op)
                        OP_WR, OP_FILL: begin
                            state_n          = S_WRITE;
                            wr_n.we[wr_idx]  = 1'b1;
                            wr_n.entry       = req_entry;
                            resp_valid_n     = 1'b1;
                        end
                        OP_RD: begin
                            state_n  = S_READ;
                            rd_idx_n = req_index;
                        end
                        OP_SRCH, OP_INV: begin
                            if (req_op == OP_INV && req_inv_op > 5'd6) begin
                                state_n        = S_WRITE;
                                resp_valid_n   = 1'b1;
                                resp_illegal_n = 1'b1;
                            end else begin
                                state_n  = S_SCAN;
                                rd_idx_n = '0;
                                issue_n  = 1'b1;
                            end
                        end
                        default: begin
                            state_n        = S_WRITE;
                            resp_valid_n   = 1'b1;
                            resp_illegal_n = 1'b1;
                        end
                    endcase
                end
            end
            S_WRITE: state_n = S_IDLE;
            S_READ: begin
                if (done_q) begin
                    state_n = S_IDLE;
                end else if (cmp_vld_q) begin
                    resp_valid_n = 1'b1;
                    resp_hit_n   = tlb_rd_entry.key.e;
                    resp_entry_n = tlb_rd_entry;
                    done_n       = 1'b1;
                end else begin
                    cmp_vld_n = 1'b1;
                end
            end
            S_SCAN: begin
                if (done_q) begin
                    state_n = S_IDLE;
                end else begin
                    if (issue_q) begin
                        cmp_vld_n = 1'b1;
                        cmp_idx_n = rd_idx_q;
                        if (rd_idx_q != LAST_IDX) begin
                            rd_idx_n = rd_idx_q + IDX_W'(1);
                            issue_n  = 1'b1;
                        end
                    end
                    if (cmp_vld_q) begin
                        if (is_inv_q) begin
                            if (inv_hit) begin
                                wr_n.we[cmp_idx_q] = 1'b1;
                                wr_n.entry         = tlb_rd_entry;
                                wr_n.entry.key.e   = 1'b0;
                            end
                            if (cmp_idx_q == LAST_IDX) begin
                                resp_valid_n = 1'b1;
                                done_n       = 1'b1;
                            end
                        end else if (srch_hit) begin
                            resp_valid_n = 1'b1;
                            resp_hit_n   = 1'b1;
                            resp_index_n = cmp_idx_q;
                            done_n       = 1'b1;
                            issue_n      = 1'b0;
                        end else if (cmp_idx_q == LAST_IDX) begin
                            resp_valid_n = 1'b1;
                            done_n       = 1'b1;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rd_idx_q       <= '0;
            cmp_idx_q      <= '0;
            issue_q        <= 1'b0;
            cmp_vld_q      <= 1'b0;
            done_q         <= 1'b0;
            is_inv_q       <= 1'b0;
            inv_op_q       <= '0;
            asid_q         <= '0;
            vpn_q          <= '0;
            wr_q           <= '0;
            resp_valid_q   <= 1'b0;
            resp_hit_q     <= 1'b0;
            resp_index_q   <= '0;
            resp_entry_q   <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_n;
            rd_idx_q       <= rd_idx_n;
            cmp_idx_q      <= cmp_idx_n;
            issue_q        <= issue_n;
            cmp_vld_q      <= cmp_vld_n;
            done_q         <= done_n;
            is_inv_q       <= is_inv_n;
            inv_op_q       <= inv_op_n;
            asid_q         <= asid_n;
            vpn_q          <= vpn_n;
            wr_q           <= wr_n;
            resp_valid_q   <= resp_valid_n;
            resp_hit_q     <= resp_hit_n;
            resp_index_q   <= resp_index_n;
            resp_entry_q   <= resp_entry_n;
            resp_illegal_q <= resp_illegal_n;
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign tlb_rd_idx      = rd_idx_q;
    assign tlb_write_req_o = wr_q;
    assign resp_valid      = resp_valid_q;
    assign resp_hit        = resp_hit_q;
    assign resp_index      = resp_index_q;
    assign resp_entry      = resp_entry_q;
    assign resp_illegal    = resp_illegal_q;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed bench for tlb_maint_ctrl with a behavioural TLB array behind a 1-cycle registered read port.
// Honours TLB_FILL_LFSR_EN for the expected TLBFILL index.
module tb_tlb_maint_ctrl;
    import tlb_maint_pkg::*;

    localparam int N     = 64;
    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_op = '0;
    logic [4:0]       req_inv_op = '0;
    logic [IDX_W-1:0] req_index = '0;
    logic [9:0]       req_asid = '0;
    logic [31:0]      req_va = '0;
    tlb_entry_t       req_entry = '0;
    logic [IDX_W-1:0] tlb_rd_idx;
    tlb_entry_t       tlb_rd_entry;
    tlb_write_req_t   tlb_write_req_o;
    logic             resp_valid;
    logic             resp_hit;
    logic [IDX_W-1:0] resp_index;
    tlb_entry_t       resp_entry;
    logic             resp_illegal;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    tlb_maint_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_inv_op      (req_inv_op),
        .req_index       (req_index),
        .req_asid        (req_asid),
        .req_va          (req_va),
        .req_entry       (req_entry),
        .tlb_rd_idx      (tlb_rd_idx),
        .tlb_rd_entry    (tlb_rd_entry),
        .tlb_write_req_o (tlb_write_req_o),
        .resp_valid      (resp_valid),
        .resp_hit        (resp_hit),
        .resp_index      (resp_index),
        .resp_entry      (resp_entry),
        .resp_illegal    (resp_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // TLB array: bulk set, single load, and DUT writes (DUT writes win)
    tlb_entry_t       mem [N];
    logic             mem_all = 1'b0;
    logic             mem_ld = 1'b0;
    logic [IDX_W-1:0] mem_ld_idx = '0;
    tlb_entry_t       mem_ld_entry = '0;

    always @(posedge clk) begin
        tlb_rd_entry <= mem[tlb_rd_idx];
        if (mem_all) begin
            for (int i = 0; i < N; i++) mem[i] <= mem_ld_entry;
        end else if (mem_ld) begin
            mem[mem_ld_idx] <= mem_ld_entry;
        end
        for (int i = 0; i < N; i++)
            if (tlb_write_req_o.we[i]) mem[i] <= tlb_write_req_o.entry;
    end

    int         wr_cyc[$];
    logic [N-1:0] wr_we[$];
    tlb_entry_t wr_ent[$];
    int         rs_cyc[$];
    logic       rs_hit[$];
    logic [IDX_W-1:0] rs_idx[$];
    tlb_entry_t rs_ent[$];
    logic       rs_ill[$];
    int         onehot_err = 0;

    always @(negedge clk) begin
        if (tlb_write_req_o.we != '0) begin
            wr_cyc.push_back(cyc);
            wr_we.push_back(tlb_write_req_o.we);
            wr_ent.push_back(tlb_write_req_o.entry);
            if ($countones(tlb_write_req_o.we) != 1) onehot_err++;
        end
        if (resp_valid) begin
            rs_cyc.push_back(cyc);
            rs_hit.push_back(resp_hit);
            rs_idx.push_back(resp_index);
            rs_ent.push_back(resp_entry);
            rs_ill.push_back(resp_illegal);
        end
    end

    function automatic tlb_entry_t mk(input logic e, input logic g, input logic huge,
                                      input logic [9:0] asid, input logic [18:0] vppn,
                                      input logic [19:0] ppn);
        tlb_entry_t t;
        t = '0;
        t.key.e    = e;
        t.key.g    = g;
        t.key.huge = huge;
        t.key.asid = asid;
        t.key.vppn = vppn;
        t.p0.ppn   = ppn;
        t.p0.v     = 1'b1;
        t.p1.ppn   = ppn ^ 20'hFFFFF;
        t.p1.d     = 1'b1;
        return t;
    endfunction

    // All stimulus tasks start and end at posedge+1
    task automatic issue(input logic [2:0] op, input logic [4:0] inv, input logic [IDX_W-1:0] idx,
                         input logic [9:0] asid, input logic [31:0] va, input tlb_entry_t ent,
                         output int t0);
        req_valid  = 1'b1;
        req_op     = op;
        req_inv_op = inv;
        req_index  = idx;
        req_asid   = asid;
        req_va     = va;
        req_entry  = ent;
        t0 = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic load(input logic [IDX_W-1:0] idx, input tlb_entry_t ent);
        mem_ld = 1'b1;
        mem_ld_idx = idx;
        mem_ld_entry = ent;
        @(posedge clk); #1;
        mem_ld = 1'b0;
    endtask

    task automatic load_all(input tlb_entry_t ent);
        mem_all = 1'b1;
        mem_ld_entry = ent;
        @(posedge clk); #1;
        mem_all = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_all = 1'b1;
        mem_ld_entry = '0;
        repeat (3) @(posedge clk);
        #1;
        mem_all = 1'b0;
        n_cmp++; if (tlb_write_req_o.we !== '0) begin n_err++; $display("FAIL reset_we: got %0h want 0", tlb_write_req_o.we); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %0b want 0", resp_valid); end
        n_cmp++; if (tlb_rd_idx !== '0) begin n_err++; $display("FAIL reset_rd_idx: got %0d want 0", tlb_rd_idx); end
        n_cmp++; if (resp_illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %0b want 0", resp_illegal); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
    endtask

    task automatic test_fill();
        int t0, wb;
        logic [IDX_W-1:0] exp_idx;
        tlb_entry_t e;
        logic [15:0] l;
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
`ifdef TLB_FILL_LFSR_EN
        l = 16'hACE1;
        repeat (10) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        exp_idx = l[IDX_W-1:0];
`else
        l = 16'd10;
        exp_idx = l[IDX_W-1:0];
`endif
        e = mk(1'b1, 1'b0, 1'b0, 10'd1, 19'h0ABCD, 20'h11111);
        wb = wr_cyc.size();
        issue(3'd3, 5'd0, 6'd0, 10'd0, 32'd0, e, t0);
        n_cmp++; if (tlb_write_req_o.we !== (64'd1 << exp_idx)) begin n_err++; $display("FAIL fill_we: got %0h want %0h", tlb_write_req_o.we, 64'd1 << exp_idx); end
        n_cmp++; if (tlb_write_req_o.entry !== e) begin n_err++; $display("FAIL fill_entry: got %0h want %0h", tlb_write_req_o.entry, e); end
        n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL fill_resp: got %0b want 1", resp_valid); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (wr_cyc.size() - wb !== 1) begin n_err++; $display("FAIL fill_count: got %0d want 1", wr_cyc.size() - wb); end
    endtask

    task automatic test_write();
        int t0;
        tlb_entry_t e;
        e = mk(1'b1, 1'b1, 1'b0, 10'd2, 19'h05555, 20'h22222);
        issue(3'd2, 5'd0, 6'd5, 10'd0, 32'd0, e, t0);
        n_cmp++; if (tlb_write_req_o.we !== 64'h20) begin n_err++; $display("FAIL wr_we: got %0h want 20", tlb_write_req_o.we); end
        n_cmp++; if (tlb_write_req_o.entry !== e) begin n_err++; $display("FAIL wr_entry: got %0h want %0h", tlb_write_req_o.entry, e); end
        n_cmp++; if (resp_valid !== 1'b1 || resp_illegal !== 1'b0) begin n_err++; $display("FAIL wr_resp: got v=%0b ill=%0b want v=1 ill=0", resp_valid, resp_illegal); end
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL wr_busy: got %0b want 0", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if (tlb_write_req_o.we !== '0) begin n_err++; $display("FAIL wr_pulse_len: got %0h want 0", tlb_write_req_o.we); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %0b want 1", req_ready); end
    endtask

    task automatic test_back_to_back();
        int t0;
        tlb_entry_t e1, e2;
        e1 = mk(1'b1, 1'b0, 1'b0, 10'd7, 19'h00001, 20'h00001);
        e2 = mk(1'b1, 1'b0, 1'b0, 10'd7, 19'h00002, 20'h00002);
        issue(3'd2, 5'd0, 6'd1, 10'd0, 32'd0, e1, t0);
        req_valid = 1'b1;
        req_index = 6'd2;
        req_entry = e2;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy: got %0b want 0", req_ready); end
        n_cmp++; if (tlb_write_req_o.we !== 64'h2) begin n_err++; $display("FAIL b2b_we1: got %0h want 2", tlb_write_req_o.we); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++; if (tlb_write_req_o.we !== 64'h4 || tlb_write_req_o.entry !== e2) begin n_err++; $display("FAIL b2b_we2: got %0h want 4", tlb_write_req_o.we); end
        @(posedge clk); #1;
    endtask

    task automatic test_srch();
        int t0, rb, wb;
        bit to;
        tlb_entry_t e7, e20;
        e7  = mk(1'b1, 1'b0, 1'b0, 10'd3, 19'h01234, 20'h07777);
        e20 = mk(1'b1, 1'b1, 1'b1, 10'd9, {10'h2A5, 9'h1FF}, 20'h02020);
        load_all('0);
        load(6'd7, e7);
        load(6'd20, e20);
        wb = wr_cyc.size();

        rb = rs_cyc.size();
        issue(3'd0, 5'd0, 6'd0, 10'd3, {19'h01234, 13'h0}, '0, t0);
        wait_idle(to);
        n_cmp++; if (to) begin n_err++; $display("FAIL srch_hit_timeout: got busy want idle"); end
        n_cmp++; if (rs_cyc.size() - rb !== 1) begin n_err++; $display("FAIL srch_hit_count: got %0d want 1", rs_cyc.size() - rb); end
        else begin
            n_cmp++; if (rs_cyc[rb] - t0 !== 10) begin n_err++; $display("FAIL srch_hit_lat: got %0d want 10", rs_cyc[rb] - t0); end
            n_cmp++; if (rs_hit[rb] !== 1'b1 || rs_idx[rb] !== 6'd7) begin n_err++; $display("FAIL srch_hit_res: got hit=%0b idx=%0d want hit=1 idx=7", rs_hit[rb], rs_idx[rb]); end
        end

        rb = rs_cyc.size();
        issue(3'd0, 5'd0, 6'd0, 10'd4, {19'h01234, 13'h0}, '0, t0);
        wait_idle(to);
        n_cmp++; if (rs_cyc.size() - rb !== 1) begin n_err++; $display("FAIL srch_miss_count: got %0d want 1", rs_cyc.size() - rb); end
        else begin
            n_cmp++; if (rs_cyc[rb] - t0 !== 66) begin n_err++; $display("FAIL srch_miss_lat: got %0d want 66", rs_cyc[rb] - t0); end
            n_cmp++; if (rs_hit[rb] !== 1'b0 || rs_idx[rb] !== 6'd0) begin n_err++; $display("FAIL srch_miss_res: got hit=%0b idx=%0d want hit=0 idx=0", rs_hit[rb], rs_idx[rb]); end
        end

        // Huge global page: only va[31:22] matters, asid ignored
        rb = rs_cyc.size();
        issue(3'd0, 5'd0, 6'd0, 10'd0, {10'h2A5, 22'h0}, '0, t0);
        wait_idle(to);
        n_cmp++; if (rs_cyc.size() - rb !== 1) begin n_err++; $display("FAIL srch_huge_count: got %0d want 1", rs_cyc.size() - rb); end
        else begin
            n_cmp++; if (rs_cyc[rb] - t0 !== 23 || rs_idx[rb] !== 6'd20 || rs_hit[rb] !== 1'b1) begin n_err++; $display("FAIL srch_huge: got lat=%0d idx=%0d hit=%0b want lat=23 idx=20 hit=1", rs_cyc[rb] - t0, rs_idx[rb], rs_hit[rb]); end
        end
        n_cmp++; if (wr_cyc.size() !== wb) begin n_err++; $display("FAIL srch_no_write: got %0d want 0", wr_cyc.size() - wb); end
    endtask

    task automatic test_read();
        int t0, rb;
        bit to;
        tlb_entry_t e20;
        e20 = mk(1'b1, 1'b1, 1'b1, 10'd9, {10'h2A5, 9'h1FF}, 20'h02020);
        rb = rs_cyc.size();
        issue(3'd1, 5'd0, 6'd20, 10'd0, 32'd0, '0, t0);
        n_cmp++; if (tlb_rd_idx !== 6'd20) begin n_err++; $display("FAIL rd_idx: got %0d want 20", tlb_rd_idx); end
        wait_idle(to);
        n_cmp++; if (rs_cyc.size() - rb !== 1) begin n_err++; $display("FAIL rd_count: got %0d want 1", rs_cyc.size() - rb); end
        else begin
            n_cmp++; if (rs_cyc[rb] - t0 !== 3) begin n_err++; $display("FAIL rd_lat: got %0d want 3", rs_cyc[rb] - t0); end
            n_cmp++; if (rs_hit[rb] !== 1'b1 || rs_ent[rb] !== e20) begin n_err++; $display("FAIL rd_data: got hit=%0b ent=%0h want hit=1 ent=%0h", rs_hit[rb], rs_ent[rb], e20); end
        end
        rb = rs_cyc.size();
        issue(3'd1, 5'd0, 6'd30, 10'd0, 32'd0, '0, t0);
        wait_idle(to);
        n_cmp++; if (rs_cyc.size() - rb !== 1) begin n_err++; $display("FAIL rd_empty_count: got %0d want 1", rs_cyc.size() - rb); end
        else begin
            n_cmp++; if (rs_hit[rb] !== 1'b0 || rs_ent[rb] !== '0) begin n_err++; $display("FAIL rd_empty: got hit=%0b ent=%0h want hit=0 ent=0", rs_hit[rb], rs_ent[rb]); end
        end
    endtask

    task automatic test_inv();
        int t0, rb, wb;
        bit to;
        tlb_entry_t g0, g10, g63, x;
        int exp_cyc[3];
        logic [N-1:0] exp_we[3];
        tlb_entry_t exp_ent[3];
        g0  = mk(1'b1, 1'b1, 1'b0, 10'd5, 19'h00100, 20'h00A00);
        g10 = mk(1'b1, 1'b1, 1'b0, 10'd6, 19'h00200, 20'h00B00);
        g63 = mk(1'b1, 1'b1, 1'b1, 10'd7, 19'h00300, 20'h00C00);
        load_all(mk(1'b1, 1'b0, 1'b0, 10'd5, 19'h00777, 20'h00D00));
        load(6'd0, g0);
        load(6'd10, g10);
        load(6'd63, g63);
        exp_cyc = '{3, 13, 66};
        exp_we  = '{64'h1, 64'h400, 64'h8000_0000_0000_0000};
        x = g0;  x.key.e = 1'b0; exp_ent[0] = x;
        x = g10; x.key.e = 1'b0; exp_ent[1] = x;
        x = g63; x.key.e = 1'b0; exp_ent[2] = x;
        wb = wr_cyc.size();
        rb = rs_cyc.size();
        issue(3'd4, 5'd2, 6'd0, 10'd0, 32'd0, '0, t0);
        wait_idle(to);
        n_cmp++; if (to) begin n_err++; $display("FAIL inv_g_timeout: got busy want idle"); end
        n_cmp++; if (wr_cyc.size() - wb !== 3) begin n_err++; $display("FAIL inv_g_count: got %0d want 3", wr_cyc.size() - wb); end
        else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (wr_cyc[wb+k] - t0 !== exp_cyc[k] || wr_we[wb+k] !== exp_we[k] || wr_ent[wb+k] !== exp_ent[k]) begin
                    n_err++;
                    $display("FAIL inv_g_write%0d: got lat=%0d we=%0h ent=%0h want lat=%0d we=%0h ent=%0h", k,
                             wr_cyc[wb+k] - t0, wr_we[wb+k], wr_ent[wb+k], exp_cyc[k], exp_we[k], exp_ent[k]);
                end
            end
        end
        n_cmp++; if (rs_cyc.size() - rb !== 1) begin n_err++; $display("FAIL inv_g_resp_count: got %0d want 1", rs_cyc.size() - rb); end
        else begin
            n_cmp++; if (rs_cyc[rb] - t0 !== 66 || rs_ill[rb] !== 1'b0) begin n_err++; $display("FAIL inv_g_resp: got lat=%0d ill=%0b want lat=66 ill=0", rs_cyc[rb] - t0, rs_ill[rb]); end
        end

        // Non-global sweep: entries 1..9, 11..62 remain valid and g=0
        wb = wr_cyc.size();
        issue(3'd4, 5'd3, 6'd0, 10'd0, 32'd0, '0, t0);
        wait_idle(to);
        n_cmp++; if (wr_cyc.size() - wb !== 61) begin n_err++; $display("FAIL inv_ng_count: got %0d want 61", wr_cyc.size() - wb); end
        else begin
            n_cmp++; if (wr_cyc[wb] - t0 !== 4 || wr_cyc[wb+60] - t0 !== 65) begin n_err++; $display("FAIL inv_ng_span: got %0d..%0d want 4..65", wr_cyc[wb] - t0, wr_cyc[wb+60] - t0); end
        end
        n_cmp++; if (onehot_err !== 0) begin n_err++; $display("FAIL onehot: got %0d multi-bit writes want 0", onehot_err); end
    endtask

    task automatic test_illegal();
        int t0, wb;
        wb = wr_cyc.size();
        issue(3'd4, 5'd7, 6'd0, 10'd0, 32'd0, '0, t0);
        n_cmp++; if (resp_valid !== 1'b1 || resp_illegal !== 1'b1) begin n_err++; $display("FAIL ill_inv: got v=%0b ill=%0b want v=1 ill=1", resp_valid, resp_illegal); end
        @(posedge clk); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL ill_inv_ready: got %0b want 1", req_ready); end
        issue(3'd6, 5'd0, 6'd3, 10'd0, 32'd0, mk(1'b1, 1'b0, 1'b0, 10'd0, 19'h0, 20'h0), t0);
        n_cmp++; if (resp_valid !== 1'b1 || resp_illegal !== 1'b1) begin n_err++; $display("FAIL ill_op: got v=%0b ill=%0b want v=1 ill=1", resp_valid, resp_illegal); end
        @(posedge clk); #1;
        n_cmp++; if (wr_cyc.size() !== wb) begin n_err++; $display("FAIL ill_no_write: got %0d want 0", wr_cyc.size() - wb); end
    endtask

    task automatic test_reset_mid();
        int t0, wb, rb;
        load_all(mk(1'b1, 1'b1, 1'b0, 10'd1, 19'h00042, 20'h00E00));
        wb = wr_cyc.size();
        rb = rs_cyc.size();
        issue(3'd4, 5'd0, 6'd0, 10'd0, 32'd0, '0, t0);
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %0b want 1", req_ready); end
        repeat (70) @(posedge clk);
        #1;
        n_cmp++; if (wr_cyc.size() - wb !== 18) begin n_err++; $display("FAIL rstmid_writes: got %0d want 18", wr_cyc.size() - wb); end
        else begin
            n_cmp++; if (wr_cyc[wb+17] - t0 !== 20) begin n_err++; $display("FAIL rstmid_last: got %0d want 20", wr_cyc[wb+17] - t0); end
        end
        n_cmp++; if (rs_cyc.size() !== rb) begin n_err++; $display("FAIL rstmid_resp: got %0d want 0", rs_cyc.size() - rb); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write();
        test_back_to_back();
        test_srch();
        test_read();
        test_inv();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
